dbg_run_ctrl: RTL and testbench

//  Multi-channel run-control engine for the sys_clk debug domain. It is the successor to the single-core RUN/HALT/STEP gate.

---
 rtl/dbg_run_ctrl.sv | 119 +++++++++++
 tb/tb_dbg_run_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dbg_run_ctrl.sv
// Multi-channel run-control engine: halt/resume/step command strobes drive
// registered per-channel clock enables, with N-cycle stepping and a cycle-count breakpoint.
module dbg_run_ctrl #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned STEP_W = 8,
  parameter int unsigned BRK_W  = 16
) (
  input  logic              sys_clk,
  input  logic              dbg_rst,
  input  logic              halt_req,
  input  logic              resume_req,
  input  logic              step_req,
  input  logic [NUM_CH-1:0] ch_sel,
  input  logic [STEP_W-1:0] step_count,
  input  logic              brk_en,
  input  logic [BRK_W-1:0]  brk_cycles,
  output logic [NUM_CH-1:0] clk_en,
  output logic [NUM_CH-1:0] halted,
  output logic              busy,
  output logic              step_done,
  output logic              brk_hit
);

  typedef enum logic [0:0] {IDLE, STEP} state_t;

  state_t              state, state_n;
  logic [NUM_CH-1:0]   run_mask, run_mask_n;
  logic [NUM_CH-1:0]   step_ch, step_ch_n;
  logic [STEP_W-1:0]   step_cnt, step_cnt_n;
  logic [BRK_W-1:0]    brk_cnt, brk_cnt_n;
  logic                hit, done, brk_act;

  always_comb begin
    state_n    = state;
    run_mask_n = run_mask;
    step_ch_n  = step_ch;
    step_cnt_n = step_cnt;
    brk_cnt_n  = brk_cnt;
    hit        = 1'b0;
    done       = 1'b0;
    brk_act    = brk_en && (brk_cycles != '0) && (|clk_en);

    unique case (state)
      IDLE: begin
        step_ch_n = '0;
        if (halt_req)
          run_mask_n = run_mask_n & ~ch_sel;
        if (resume_req)
          run_mask_n = run_mask_n | (ch_sel & ~(halt_req ? ch_sel : '0));

        // A breakpoint hit overrides a coincident resume/step: everything halts.
        if (!brk_en) begin
          brk_cnt_n = '0;
        end else if (brk_act && (brk_cnt + BRK_W'(1) == brk_cycles)) begin
          hit        = 1'b1;
          run_mask_n = '0;
          brk_cnt_n  = '0;
        end else if (resume_req) begin
          brk_cnt_n = '0;
        end else if (brk_act) begin
          brk_cnt_n = brk_cnt + BRK_W'(1);
        end

        if (step_req && !hit) begin
          step_ch_n = ch_sel & ~run_mask_n;
          if (step_ch_n != '0) begin
            state_n    = STEP;
            step_cnt_n = (step_count == '0) ? STEP_W'(1) : step_count;
          end
        end
      end

      STEP: begin
        if (halt_req) begin
          run_mask_n = run_mask_n & ~ch_sel;
          step_ch_n  = step_ch_n & ~ch_sel;
        end
        if (step_ch_n == '0) begin
          state_n = IDLE;
        end else if (step_cnt == STEP_W'(1)) begin
          state_n   = IDLE;
          step_ch_n = '0;
          done      = 1'b1;
        end else begin
          step_cnt_n = step_cnt - STEP_W'(1);
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!dbg_rst) begin
      state     <= IDLE;
      run_mask  <= '1;
      step_ch   <= '0;
      step_cnt  <= '0;
      brk_cnt   <= '0;
      clk_en    <= '1;
      halted    <= '0;
      busy      <= 1'b0;
      step_done <= 1'b0;
      brk_hit   <= 1'b0;
    end else begin
      state     <= state_n;
      run_mask  <= run_mask_n;
      step_ch   <= step_ch_n;
      step_cnt  <= step_cnt_n;
      brk_cnt   <= brk_cnt_n;
      clk_en    <= run_mask_n | step_ch_n;
      halted    <= ~run_mask_n;
      busy      <= (state_n == STEP);
      step_done <= done;
      brk_hit   <= hit;
    end
  end

endmodule

// File: tb/tb_dbg_run_ctrl.sv
// Directed bench for dbg_run_ctrl: halt/resume, stepping, guards, breakpoint, reset mid-step.
module tb_dbg_run_ctrl;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned STEP_W = 8;
  localparam int unsigned BRK_W  = 16;

  logic              sys_clk = 1'b0;
  logic              dbg_rst = 1'b0;
  logic              halt_req = 1'b0, resume_req = 1'b0, step_req = 1'b0;
  logic [NUM_CH-1:0] ch_sel = '0;
  logic [STEP_W-1:0] step_count = '0;
  logic              brk_en = 1'b0;
  logic [BRK_W-1:0]  brk_cycles = '0;
  logic [NUM_CH-1:0] clk_en, halted;
  logic              busy, step_done, brk_hit;

  int n_checks = 0;
  int n_pass   = 0;
  int n;
  int bad;

  dbg_run_ctrl #(.NUM_CH(NUM_CH), .STEP_W(STEP_W), .BRK_W(BRK_W)) dut (
    .sys_clk(sys_clk), .dbg_rst(dbg_rst),
    .halt_req(halt_req), .resume_req(resume_req), .step_req(step_req),
    .ch_sel(ch_sel), .step_count(step_count),
    .brk_en(brk_en), .brk_cycles(brk_cycles),
    .clk_en(clk_en), .halted(halted), .busy(busy),
    .step_done(step_done), .brk_hit(brk_hit)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic cmd(input logic h, input logic r, input logic s, input logic [NUM_CH-1:0] sel);
    halt_req = h; resume_req = r; step_req = s; ch_sel = sel;
    tick();
    halt_req = 1'b0; resume_req = 1'b0; step_req = 1'b0;
  endtask

  initial begin
    // T1 reset
    tick(); tick();
    chk("rst_clk_en", 32'(clk_en), 32'h3);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(step_done), 0);
    chk("rst_brk", 32'(brk_hit), 0);
    dbg_rst = 1'b1;
    tick();

    // T2 halt / resume
    cmd(1, 0, 0, 2'b01);
    chk("halt01_clk_en", 32'(clk_en), 32'h2);
    chk("halt01_halted", 32'(halted), 32'h1);
    cmd(0, 1, 0, 2'b01);
    chk("resume01_clk_en", 32'(clk_en), 32'h3);
    chk("resume01_halted", 32'(halted), 32'h0);
    cmd(1, 1, 0, 2'b10);
    chk("halt_wins_halted", 32'(halted), 32'h2);
    chk("halt_wins_clk_en", 32'(clk_en), 32'h1);

    // T3 step both channels, 3 cycles then 0 -> 1 cycle
    cmd(1, 0, 0, 2'b11);
    chk("halt11_clk_en", 32'(clk_en), 32'h0);
    step_count = 8'd3;
    cmd(0, 0, 1, 2'b11);
    n = 0; bad = 0;
    while (clk_en == 2'b11 && n < 20) begin
      if (busy !== 1'b1 || step_done !== 1'b0) bad++;
      n++; tick();
    end
    chk("step3_len", 32'(n), 3);
    chk("step3_busy", 32'(bad), 0);
    chk("step3_done", 32'(step_done), 1);
    chk("step3_clk_after", 32'(clk_en), 32'h0);
    chk("step3_busy_after", 32'(busy), 0);
    tick();
    chk("step3_done_pulse", 32'(step_done), 0);

    step_count = 8'd0;
    cmd(0, 0, 1, 2'b11);
    n = 0;
    while (clk_en == 2'b11 && n < 20) begin n++; tick(); end
    chk("step0_len", 32'(n), 1);
    chk("step0_done", 32'(step_done), 1);

    // T4 guards: step on running-only mask is ignored
    cmd(0, 1, 0, 2'b01);
    step_count = 8'd4;
    cmd(0, 0, 1, 2'b01);
    chk("step_run_busy", 32'(busy), 0);
    chk("step_run_clk_en", 32'(clk_en), 32'h1);
    tick();
    chk("step_run_done", 32'(step_done), 0);

    // step_req while busy must not restart the step
    step_count = 8'd5;
    cmd(0, 0, 1, 2'b10);
    n = 0;
    while (clk_en[1] && n < 300) begin
      n++;
      step_req = (n == 1); ch_sel = 2'b10; step_count = 8'd100;
      tick();
    end
    step_req = 1'b0;
    chk("step_busy_len", 32'(n), 5);
    chk("step_busy_done", 32'(step_done), 1);
    chk("step_busy_clk_en", 32'(clk_en), 32'h1);

    // halt everything mid-step aborts without step_done
    step_count = 8'd10;
    cmd(0, 0, 1, 2'b10);
    chk("abort_pre_clk_en", 32'(clk_en), 32'h3);
    tick();
    cmd(1, 0, 0, 2'b11);
    chk("abort_clk_en", 32'(clk_en), 32'h0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(step_done), 0);
    chk("abort_halted", 32'(halted), 32'h3);
    tick();
    chk("abort_done_late", 32'(step_done), 0);

    // T5 breakpoint after 5 enabled cycles
    brk_en = 1'b1; brk_cycles = 16'd5;
    cmd(0, 1, 0, 2'b11);
    n = 0; bad = 0;
    while (clk_en == 2'b11 && n < 50) begin
      if (brk_hit !== 1'b0) bad++;
      n++; tick();
    end
    chk("brk5_len", 32'(n), 5);
    chk("brk5_early_hit", 32'(bad), 0);
    chk("brk5_hit", 32'(brk_hit), 1);
    chk("brk5_clk_en", 32'(clk_en), 32'h0);
    chk("brk5_halted", 32'(halted), 32'h3);
    tick();
    chk("brk5_hit_pulse", 32'(brk_hit), 0);

    // halt coinciding with the hit cycle: hit still pulses
    brk_cycles = 16'd3;
    cmd(0, 1, 0, 2'b11);
    tick(); tick();
    cmd(1, 0, 0, 2'b01);
    chk("brk_halt_hit", 32'(brk_hit), 1);
    chk("brk_halt_clk_en", 32'(clk_en), 32'h0);

    // brk_cycles=0 disables the breakpoint
    brk_cycles = 16'd0;
    cmd(0, 1, 0, 2'b11);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (clk_en !== 2'b11 || brk_hit !== 1'b0) bad++;
      tick();
    end
    chk("brk0_free_run", 32'(bad), 0);
    brk_en = 1'b0;

    // T6 reset mid-step
    cmd(1, 0, 0, 2'b11);
    step_count = 8'd200;
    cmd(0, 0, 1, 2'b11);
    chk("t6_busy", 32'(busy), 1);
    for (int i = 0; i < 9; i++) tick();
    dbg_rst = 1'b0;
    tick();
    chk("t6_rst_clk_en", 32'(clk_en), 32'h3);
    chk("t6_rst_halted", 32'(halted), 32'h0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_done", 32'(step_done), 0);
    dbg_rst = 1'b1;
    tick();
    chk("t6_post_done", 32'(step_done), 0);
    chk("t6_post_clk_en", 32'(clk_en), 32'h3);
    chk("t6_post_busy", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
